seq_add_64bit: RTL and testbench



---
 rtl/seq_add_64bit.sv | 125 ++++++++++++
 tb/tb_seq_add_64bit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_add_64bit.sv
// seq_add_64bit
// Multi-cycle 64-bit adder/accumulator. One 16-bit ripple slice is reused over
// four RUN cycles, least-significant slice first, with a registered carry
// between slices. Every completed sum is also written to an internal
// accumulator. That accumulator can replace operand B on the next operation.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   In_valid/In_ready   operand handshake (In_ready only in IDLE)
//   A, B, Cin      operands and carry-in (B ignored when Acc_en=1)
//   Acc_en         use the accumulator as second operand
//   Clr            clear the accumulator (IDLE only)
//   Out_valid/Out_ready result handshake (Out_valid only in DONE)
//   Sum, Cout      registered 64-bit result and carry out of bit 63
module seq_add_64bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Cin,
    input  logic        Acc_en,
    input  logic        Clr,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [63:0] Sum,
    output logic        Cout
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        carry_q, carry_d;
    logic [47:0] work_q, work_d;    // slices 0..2; slice 3 goes straight to Sum
    logic [63:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic [63:0] acc_q, acc_d;

    logic [15:0] slice_a, slice_b;
    logic [16:0] slice_sum;

    // The carry register is loaded with Cin on accept, so slice 0 takes its
    // carry-in from the same place as the later slices.
    assign slice_a   = a_q[{k_q, 4'b0000} +: 16];
    assign slice_b   = b_q[{k_q, 4'b0000} +: 16];
    assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {16'b0, carry_q};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (Clr) acc_d = 64'd0;
                if (In_valid) begin
                    a_d     = A;
                    // Clr and Acc_en together means "start from zero".
                    b_d     = Acc_en ? (Clr ? 64'd0 : acc_q) : B;
                    carry_d = Cin;
                    k_d     = 2'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = slice_sum[16];
                k_d     = k_q + 2'd1;
                case (k_q)
                    2'd0: work_d[15:0]  = slice_sum[15:0];
                    2'd1: work_d[31:16] = slice_sum[15:0];
                    2'd2: work_d[47:32] = slice_sum[15:0];
                    default: begin
                        sum_d   = {slice_sum[15:0], work_q};
                        cout_d  = slice_sum[16];
                        acc_d   = {slice_sum[15:0], work_q};
                        state_d = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                if (Out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            carry_q <= 1'b0;
            work_q  <= 48'd0;
            sum_q   <= 64'd0;
            cout_q  <= 1'b0;
            acc_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            acc_q   <= acc_d;
        end
    end

    assign In_ready  = (state_q == S_IDLE);
    assign Out_valid = (state_q == S_DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_seq_add_64bit.sv
module tb_seq_add_64bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_valid;
    logic        In_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        Cin;
    logic        Acc_en;
    logic        Clr;
    logic        Out_valid;
    logic        Out_ready;
    logic [63:0] Sum;
    logic        Cout;

    int checks = 0;
    int errors = 0;

    seq_add_64bit dut (
        .clk(clk), .rst(rst),
        .In_valid(In_valid), .In_ready(In_ready),
        .A(A), .B(B), .Cin(Cin), .Acc_en(Acc_en), .Clr(Clr),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Sum(Sum), .Cout(Cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one operation, wait (bounded) for Out_valid, check latency and
    // result, then complete the handshake with Out_ready=1.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic acc_en, input logic clr,
                          input logic [63:0] exp_sum, input logic exp_cout);
        int cyc;
        @(negedge clk);
        A = a; B = b; Cin = cin; Acc_en = acc_en; Clr = clr; In_valid = 1'b1;
        @(posedge clk); #1;
        In_valid = 1'b0; Clr = 1'b0; Acc_en = 1'b0;
        cyc = 0;
        while (!Out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd4);
        check({tag, "_sum"}, Sum, exp_sum);
        check({tag, "_cout"}, 64'(Cout), 64'(exp_cout));
        @(posedge clk); #1;
        check({tag, "_idle"}, 64'(In_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; In_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        Acc_en = 1'b0; Clr = 1'b0; Out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(In_ready), 64'd1);
        check("rst_out_valid", 64'(Out_valid), 64'd0);
        check("rst_sum", Sum, 64'd0);
        check("rst_cout", 64'(Cout), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Full-width carry chain
        run_op("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        // Carry across slice boundaries
        run_op("cin_slice", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0);
        run_op("slice3", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0,
               64'h0001_0000_0000_0000, 1'b0);
        // Result held in IDLE
        repeat (3) @(posedge clk);
        #1 check("hold_idle", Sum, 64'h0001_0000_0000_0000);

        // Accumulate: Clr alone in IDLE, then two accumulate steps
        @(negedge clk); Clr = 1'b1;
        @(negedge clk); Clr = 1'b0;
        check("clr_no_accept", 64'(In_ready), 64'd1);
        run_op("acc5", 64'd5, 64'hDEAD, 1'b0, 1'b1, 1'b0, 64'd5, 1'b0);
        run_op("acc7", 64'd7, 64'hDEAD, 1'b0, 1'b1, 1'b0, 64'hC, 1'b0);
        run_op("plain", 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 64'd3, 1'b0);
        run_op("acc_is3", 64'd0, 64'hBEEF, 1'b0, 1'b1, 1'b0, 64'd3, 1'b0);

        // Backpressure
        @(negedge clk); Out_ready = 1'b0;
        A = 64'h10; B = 64'h20; Cin = 1'b0; Acc_en = 1'b0; In_valid = 1'b1;
        @(posedge clk); #1 In_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("bp_valid_rise", 64'(Out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) begin A = 64'd9; B = 64'd0; In_valid = 1'b1; end
            else In_valid = 1'b0;
            @(posedge clk); #1;
            check("bp_out_valid", 64'(Out_valid), 64'd1);
            check("bp_sum", Sum, 64'h30);
            check("bp_in_ready", 64'(In_ready), 64'd0);
        end
        @(negedge clk); In_valid = 1'b0; Out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_idle", 64'(In_ready), 64'd1);
        check("bp_hs_valid", 64'(Out_valid), 64'd0);
        @(posedge clk); #1;
        check("bp_no_accept", 64'(In_ready), 64'd1);
        check("bp_sum_after", Sum, 64'h30);

        // Reset in the middle of RUN
        @(negedge clk); A = 64'd1; B = 64'd1; In_valid = 1'b1;
        @(posedge clk); #1 In_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; #1;
        check("mid_rst_valid", 64'(Out_valid), 64'd0);
        check("mid_rst_ready", 64'(In_ready), 64'd1);
        check("mid_rst_sum", Sum, 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op("acc_zeroed", 64'd2, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b0);
        run_op("after_rst", 64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 64'd5, 1'b0);

        // Clr + accept with Acc_en=1 uses zero, not the prior accumulator
        run_op("set100", 64'h100, 64'd0, 1'b0, 1'b0, 1'b0, 64'h100, 1'b0);
        run_op("clr_acc", 64'd3, 64'hFFFF, 1'b0, 1'b1, 1'b1, 64'd3, 1'b0);
        // Clr + accept with Acc_en=0 uses B
        run_op("clr_b", 64'd4, 64'd6, 1'b0, 1'b0, 1'b1, 64'd10, 1'b0);
        run_op("acc_wrap", 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, 1'b1, 1'b0, 64'd2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
